// File: rtl/sram_1r1w_ext.sv
// ---------------------------------------------------------------------------
// sram_1r1w_ext
//   Behavioural 1-read / 1-write SRAM model on a single clock. The model
//   has a configurable depth, width and write-mask granularity. It has a
//   registered read-valid, and after every reset it zero-fills the whole
//   array before it accepts any request.
//
//   Build option:
//     SRAM_BYPASS_EN  defined   -> a same-address read in the same cycle as
//                                  a write returns the merged (post-write)
//                                  data.
//                     undefined -> the read returns the prior contents
//                                  (read-first).
//
//   Ports:
//     clock      in   rising-edge clock
//     reset      in   asynchronous, active-high reset
//     init_done  out  high once zero-initialisation has completed
//     R0_en      in   read request
//     R0_addr    in   read address
//     R0_rvalid  out  R0_data holds the result of last cycle's read
//     R0_data    out  registered read data
//     W0_en      in   write request
//     W0_addr    in   write address
//     W0_data    in   write data
//     W0_mask    in   per-lane write enable (lane i = bits [i*MASK_GRAN +: MASK_GRAN])
// ---------------------------------------------------------------------------
module sram_1r1w_ext #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned MASK_GRAN = 8,
    parameter int unsigned ADDR_W    = $clog2(DEPTH),
    parameter int unsigned MASK_SEG  = WIDTH / MASK_GRAN
) (
    input  logic                clock,
    input  logic                reset,
    output logic                init_done,
    input  logic                R0_en,
    input  logic [ADDR_W-1:0]   R0_addr,
    output logic                R0_rvalid,
    output logic [WIDTH-1:0]    R0_data,
    input  logic                W0_en,
    input  logic [ADDR_W-1:0]   W0_addr,
    input  logic [WIDTH-1:0]    W0_data,
    input  logic [MASK_SEG-1:0] W0_mask
);

    typedef enum logic {
        INIT,
        READY
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              ready;
    logic              wr_fire;
    logic              rd_fire;
    logic [WIDTH-1:0]  rd_raw;
    logic [WIDTH-1:0]  rd_next;

    logic              rvalid_q;
    logic [WIDTH-1:0]  rdata_q;

    // ---------------------------------------------------------------------
    // Init sequencer
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready     = (state_q == READY);
    assign init_done = ready;

    // Writes to addresses at or above DEPTH are dropped. This only matters
    // when DEPTH is not a power of two.
    assign wr_fire = ready && W0_en && ({1'b0, W0_addr} < DEPTH_EXT);
    assign rd_fire = ready && R0_en;

    // ---------------------------------------------------------------------
    // Array. It has no reset, because its contents are not guaranteed until
    // the init sweep has run.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!ready) begin
            mem[cnt_q] <= '0;
        end else if (wr_fire) begin
            for (int unsigned i = 0; i < MASK_SEG; i++) begin
                if (W0_mask[i]) begin
                    mem[W0_addr][i*MASK_GRAN +: MASK_GRAN] <= W0_data[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    assign rd_raw = mem[R0_addr];

`ifdef SRAM_BYPASS_EN
    // Forward the masked write lanes into a same-address read, so that the
    // read sees the post-write contents.
    always_comb begin
        rd_next = rd_raw;
        if (wr_fire && (W0_addr == R0_addr)) begin
            for (int unsigned i = 0; i < MASK_SEG; i++) begin
                if (W0_mask[i]) begin
                    rd_next[i*MASK_GRAN +: MASK_GRAN] = W0_data[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end
`else
    always_comb begin
        rd_next = rd_raw;
    end
`endif

    // ---------------------------------------------------------------------
    // Read port. The data register holds its value on idle cycles.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rd_fire;
            if (rd_fire) begin
                rdata_q <= rd_next;
            end
        end
    end

    assign R0_rvalid = rvalid_q;
    assign R0_data   = rdata_q;

endmodule

// File: tb/tb_sram_1r1w_ext.sv
module tb_sram_1r1w_ext;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    // DEPTH=16 instance
    logic        init_done;
    logic        R0_en = 1'b0;
    logic [3:0]  R0_addr = '0;
    logic        R0_rvalid;
    logic [15:0] R0_data;
    logic        W0_en = 1'b0;
    logic [3:0]  W0_addr = '0;
    logic [15:0] W0_data = '0;
    logic [1:0]  W0_mask = '0;

    // DEPTH=12 instance
    logic        b_init_done;
    logic        b_R0_en = 1'b0;
    logic [3:0]  b_R0_addr = '0;
    logic        b_R0_rvalid;
    logic [15:0] b_R0_data;
    logic        b_W0_en = 1'b0;
    logic [3:0]  b_W0_addr = '0;
    logic [15:0] b_W0_data = '0;
    logic [1:0]  b_W0_mask = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    sram_1r1w_ext #(.DEPTH(16), .WIDTH(16), .MASK_GRAN(8)) u_dut (
        .clock(clock), .reset(reset), .init_done(init_done),
        .R0_en(R0_en), .R0_addr(R0_addr), .R0_rvalid(R0_rvalid), .R0_data(R0_data),
        .W0_en(W0_en), .W0_addr(W0_addr), .W0_data(W0_data), .W0_mask(W0_mask)
    );

    sram_1r1w_ext #(.DEPTH(12), .WIDTH(16), .MASK_GRAN(8)) u_dut12 (
        .clock(clock), .reset(reset), .init_done(b_init_done),
        .R0_en(b_R0_en), .R0_addr(b_R0_addr), .R0_rvalid(b_R0_rvalid), .R0_data(b_R0_data),
        .W0_en(b_W0_en), .W0_addr(b_W0_addr), .W0_data(b_W0_data), .W0_mask(b_W0_mask)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
        W0_en = 1'b1; W0_addr = a; W0_data = d; W0_mask = m; R0_en = 1'b0;
        step();
        W0_en = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [3:0] a, input logic [15:0] exp);
        R0_en = 1'b1; R0_addr = a; W0_en = 1'b0;
        step();
        check({tag, "_rvalid"}, 64'(R0_rvalid), 64'd1);
        check({tag, "_data"}, 64'(R0_data), 64'(exp));
        R0_en = 1'b0;
    endtask

    task automatic init_sweep(input string tag);
        for (int e = 1; e <= 16; e++) begin
            step();
            check({tag, "_init_done"}, 64'(init_done), (e >= 16) ? 64'd1 : 64'd0);
            check({tag, "_init_done12"}, 64'(b_init_done), (e >= 12) ? 64'd1 : 64'd0);
            check({tag, "_rvalid_init"}, 64'(R0_rvalid), 64'd0);
        end
    endtask

    initial begin
        logic [15:0] exp_rdw;

        // Reset state
        #2;
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_rvalid", 64'(R0_rvalid), 64'd0);
        check("rst_data", 64'(R0_data), 64'd0);
        repeat (2) @(posedge clock);

        // 1. Init sequence, with requests held active that must be dropped
        W0_en = 1'b1; W0_addr = 4'd3; W0_data = 16'hFFFF; W0_mask = 2'b11;
        R0_en = 1'b1; R0_addr = 4'd3;
        @(negedge clock);
        reset = 1'b0;
        init_sweep("init1");
        W0_en = 1'b0; R0_en = 1'b0;
        for (int a = 0; a < 16; a++) do_read("init1_zero", 4'(a), 16'h0000);

        // 2. Masked write
        do_write(4'd5, 16'hABCD, 2'b11);
        do_write(4'd5, 16'h1234, 2'b01);
        do_read("mask_lo", 4'd5, 16'hAB34);
        do_write(4'd5, 16'hFFFF, 2'b00);
        do_read("mask_none", 4'd5, 16'hAB34);

        // 3. Read during write to the same address
        do_write(4'd7, 16'h00FF, 2'b11);
`ifdef SRAM_BYPASS_EN
        exp_rdw = 16'h5AFF;
`else
        exp_rdw = 16'h00FF;
`endif
        W0_en = 1'b1; W0_addr = 4'd7; W0_data = 16'h5A5A; W0_mask = 2'b10;
        R0_en = 1'b1; R0_addr = 4'd7;
        step();
        W0_en = 1'b0; R0_en = 1'b0;
        check("rdw_rvalid", 64'(R0_rvalid), 64'd1);
        check("rdw_data", 64'(R0_data), 64'(exp_rdw));
        do_read("rdw_after", 4'd7, 16'h5AFF);

        // 4. Back-to-back reads, then an idle cycle
        do_write(4'd0, 16'd1, 2'b11);
        do_write(4'd15, 16'd2, 2'b11);
        R0_en = 1'b1; R0_addr = 4'd0;
        step();
        check("b2b0_rvalid", 64'(R0_rvalid), 64'd1);
        check("b2b0_data", 64'(R0_data), 64'd1);
        R0_addr = 4'd15;
        step();
        check("b2b1_rvalid", 64'(R0_rvalid), 64'd1);
        check("b2b1_data", 64'(R0_data), 64'd2);
        R0_en = 1'b0;
        step();
        check("idle_rvalid", 64'(R0_rvalid), 64'd0);
        check("idle_hold", 64'(R0_data), 64'd2);

        // 6. Non-power-of-two depth, top address
        b_W0_en = 1'b1; b_W0_addr = 4'd11; b_W0_data = 16'hBEEF; b_W0_mask = 2'b11;
        step();
        b_W0_en = 1'b0; b_R0_en = 1'b1; b_R0_addr = 4'd11;
        step();
        b_R0_en = 1'b0;
        check("d12_rvalid", 64'(b_R0_rvalid), 64'd1);
        check("d12_data", 64'(b_R0_data), 64'hBEEF);

        // 5. Asynchronous reset in the cycle after a read request
        R0_en = 1'b1; R0_addr = 4'd15;
        step();
        check("prerst_rvalid", 64'(R0_rvalid), 64'd1);
        R0_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_rvalid", 64'(R0_rvalid), 64'd0);
        check("async_data", 64'(R0_data), 64'd0);
        check("async_init_done", 64'(init_done), 64'd0);
        check("async_init_done12", 64'(b_init_done), 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        init_sweep("init2");
        for (int a = 0; a < 16; a++) do_read("init2_zero", 4'(a), 16'h0000);
        b_R0_en = 1'b1; b_R0_addr = 4'd11;
        step();
        b_R0_en = 1'b0;
        check("d12_reinit", 64'(b_R0_data), 64'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
